// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the RV32I ID stage: opcodes, control enums,
// the IF->ID and ID->EX pipeline records, and the bubble encoding.
package decode_stage_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [6:0] {
    OPCODE__LOAD   = 7'b0000011,
    OPCODE__FENCE  = 7'b0001111,
    OPCODE__OP_IMM = 7'b0010011,
    OPCODE__AUIPC  = 7'b0010111,
    OPCODE__STORE  = 7'b0100011,
    OPCODE__OP     = 7'b0110011,
    OPCODE__LUI    = 7'b0110111,
    OPCODE__BRANCH = 7'b1100011,
    OPCODE__JALR   = 7'b1100111,
    OPCODE__JAL    = 7'b1101111,
    OPCODE__SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    IMM_FMT__I, IMM_FMT__S, IMM_FMT__B, IMM_FMT__U, IMM_FMT__J
  } imm_fmt_t;

  typedef enum logic [2:0] {
    ALU_OP__ADD, ALU_OP__SUB, ALU_OP__FUNCT, ALU_OP__FUNCT_IMM, ALU_OP__LUI, ALU_OP__AUIPC
  } alu_op_t;

  typedef enum logic [1:0] {
    RESULT_SRC__ALU, RESULT_SRC__MEM, RESULT_SRC__PC_PLUS_4
  } result_src_t;

  typedef enum logic [1:0] {
    PC_SRC__INCREMENT, PC_SRC__JUMP, PC_SRC__ALU_RESULT
  } pc_src_t;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_cur;
    logic [31:0] pc_plus_4;
  } if_to_id_t;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           pc_cur;
    logic [31:0]           pc_plus_4;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           rd1;
    logic [31:0]           rd2;
    logic [31:0]           imm_ext;
    alu_op_t               alu_op;
    logic                  alu_src;
    result_src_t           result_src;
    logic                  reg_write;
    logic                  mem_write;
    logic                  branch;
    logic [2:0]            funct3;
    pc_src_t               pc_src;
    logic                  illegal;
  } id_to_ex_t;

  // Decode of NOP_INSTR with every side effect suppressed and valid low.
  function automatic id_to_ex_t bubble();
    id_to_ex_t b;
    b         = '0;
    b.rs1     = NOP_INSTR[19:15];
    b.rs2     = NOP_INSTR[24:20];
    b.rd      = NOP_INSTR[11:7];
    b.funct3  = NOP_INSTR[14:12];
    b.imm_ext = {{20{NOP_INSTR[31]}}, NOP_INSTR[31:20]};
    b.alu_op  = ALU_OP__FUNCT_IMM;
    b.alu_src = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one write port, x0 hardwired to zero, asynchronous active-low clear.
module decode_stage_register_file
  import decode_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_enable,
  input  logic [REG_ADDR_W-1:0]      write_addr,
  input  logic [31:0]                write_data,
  input  logic [1:0][REG_ADDR_W-1:0] read_addr,
  output logic [1:0][31:0]           read_data
);

  logic [31:0] regs_reg [NUM_REGS];
  logic        write_hit;

  assign write_hit = write_enable && (write_addr != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else if (write_hit) begin
      regs_reg[write_addr] <= write_data;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      assign read_data[gi] = (read_addr[gi] == '0)                     ? 32'd0 :
                             (write_hit && write_addr == read_addr[gi]) ? write_data :
                                                                          regs_reg[read_addr[gi]];
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decodes IF_to_ID into a registered ID_to_EX record with
// one cycle of latency, honouring hazard-unit stall and flush.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  if_to_id_t             IF_to_ID,
  input  logic                  id__stall,
  input  logic                  id__flush,
  input  logic                  wb__reg_write,
  input  logic [REG_ADDR_W-1:0] wb__rd,
  input  logic [31:0]           wb__data,
  output id_to_ex_t             ID_to_EX
);

  logic [31:0]     instr;
  opcode_t         opcode;
  imm_fmt_t        imm_fmt;
  logic [31:0]     imm_ext;
  logic [1:0][31:0] read_data;
  id_to_ex_t       ctrl;
  id_to_ex_t       decoded;
  id_to_ex_t       id_to_ex_reg;

  assign instr  = IF_to_ID.instruction;
  assign opcode = opcode_t'(instr[6:0]);

  decode_stage_register_file u_register_file (
    .clk          (clk),
    .reset        (reset),
    .write_enable (wb__reg_write),
    .write_addr   (wb__rd),
    .write_data   (wb__data),
    .read_addr    ({instr[24:20], instr[19:15]}),
    .read_data    (read_data)
  );

  always_comb begin : decoder
    ctrl            = '0;
    imm_fmt         = IMM_FMT__I;
    ctrl.valid      = 1'b1;
    ctrl.pc_cur     = IF_to_ID.pc_cur;
    ctrl.pc_plus_4  = IF_to_ID.pc_plus_4;
    ctrl.rs1        = instr[19:15];
    ctrl.rs2        = instr[24:20];
    ctrl.rd         = instr[11:7];
    ctrl.rd1        = read_data[0];
    ctrl.rd2        = read_data[1];
    ctrl.funct3     = instr[14:12];
    ctrl.alu_op     = ALU_OP__ADD;
    ctrl.result_src = RESULT_SRC__ALU;
    ctrl.pc_src     = PC_SRC__INCREMENT;
    case (opcode)
      OPCODE__OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP__FUNCT;
      end
      OPCODE__OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP__FUNCT_IMM;
        ctrl.alu_src   = 1'b1;
      end
      OPCODE__LUI, OPCODE__AUIPC: begin
        imm_fmt        = IMM_FMT__U;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = (opcode == OPCODE__LUI) ? ALU_OP__LUI : ALU_OP__AUIPC;
      end
      OPCODE__LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RESULT_SRC__MEM;
      end
      OPCODE__STORE: begin
        imm_fmt        = IMM_FMT__S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.rd        = '0;
      end
      // Branches are resolved in EX; rd bits are immediate bits here.
      OPCODE__BRANCH: begin
        imm_fmt     = IMM_FMT__B;
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_OP__SUB;
        ctrl.rd     = '0;
      end
      OPCODE__JAL: begin
        imm_fmt         = IMM_FMT__J;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RESULT_SRC__PC_PLUS_4;
        ctrl.pc_src     = PC_SRC__JUMP;
      end
      OPCODE__JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RESULT_SRC__PC_PLUS_4;
        ctrl.pc_src     = PC_SRC__ALU_RESULT;
      end
      OPCODE__FENCE, OPCODE__SYSTEM: begin
        ctrl.rd = '0;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  always_comb begin : imm_gen
    imm_ext = {{20{instr[31]}}, instr[31:20]};
    case (imm_fmt)
      IMM_FMT__S: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_FMT__B: imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_FMT__U: imm_ext = {instr[31:12], 12'b0};
      IMM_FMT__J: imm_ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:    imm_ext = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  always_comb begin
    decoded         = ctrl;
    decoded.imm_ext = imm_ext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_to_ex_reg <= '0;
    end else if (id__flush) begin
      id_to_ex_reg <= bubble();
    end else if (!id__stall) begin
      id_to_ex_reg <= decoded;
    end
  end

  assign ID_to_EX = id_to_ex_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push expected
// ID_to_EX records tagged with their cycle; a negedge monitor compares them.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int F_VALID = 0, F_PC = 1, F_RS = 2, F_RD = 3, F_RD1 = 4, F_RD2 = 5;
  localparam int F_IMM = 6, F_CTRL = 7, F_RES = 8, F_ALU = 9, F_F3 = 10;

  logic        clk = 1'b0;
  logic        reset;
  if_to_id_t   if_to_id;
  logic        stall, flush, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  id_to_ex_t   id_to_ex;

  decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .IF_to_ID      (if_to_id),
    .id__stall     (stall),
    .id__flush     (flush),
    .wb__reg_write (wb_we),
    .wb__rd        (wb_rd),
    .wb__data      (wb_data),
    .ID_to_EX      (id_to_ex)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          cyc;
    id_to_ex_t   exp;
    logic [10:0] chk;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] pc = 32'h0000_1000;
  logic [31:0] last_pc;
  id_to_ex_t   e;
  logic [10:0] c;

  task automatic check(input string name, input id_to_ex_t g, input id_to_ex_t x, input logic [10:0] k);
    bit bad;
    bad = (k[F_VALID] && g.valid !== x.valid) ||
          (k[F_PC]    && (g.pc_cur !== x.pc_cur || g.pc_plus_4 !== x.pc_plus_4)) ||
          (k[F_RS]    && (g.rs1 !== x.rs1 || g.rs2 !== x.rs2)) ||
          (k[F_RD]    && g.rd !== x.rd) ||
          (k[F_RD1]   && g.rd1 !== x.rd1) ||
          (k[F_RD2]   && g.rd2 !== x.rd2) ||
          (k[F_IMM]   && g.imm_ext !== x.imm_ext) ||
          (k[F_CTRL]  && (g.reg_write !== x.reg_write || g.mem_write !== x.mem_write ||
                          g.branch !== x.branch || g.pc_src !== x.pc_src || g.illegal !== x.illegal)) ||
          (k[F_RES]   && g.result_src !== x.result_src) ||
          (k[F_ALU]   && g.alu_src !== x.alu_src) ||
          (k[F_F3]    && g.funct3 !== x.funct3);
    n_checks++;
    if (bad) $display("FAIL %s: got=%h required=%h", name, g, x);
    else begin
      n_pass++;
      $display("ok   %s", name);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      sb_entry_t t;
      t = sb.pop_front();
      if (t.cyc < cyc) begin
        n_checks++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", t.name, cyc, t.cyc);
      end else begin
        check(t.name, id_to_ex, t.exp, t.chk);
      end
    end
  end

  task automatic step(input logic [31:0] instr, input logic st = 1'b0, input logic fl = 1'b0,
                      input logic we = 1'b0, input logic [4:0] rd = 5'd0, input logic [31:0] data = 32'd0);
    @(posedge clk);
    #1;
    if_to_id.instruction = instr;
    if_to_id.pc_cur      = pc;
    if_to_id.pc_plus_4   = pc + 32'd4;
    last_pc              = pc;
    pc                   = pc + 32'd4;
    stall   = st;
    flush   = fl;
    wb_we   = we;
    wb_rd   = rd;
    wb_data = data;
  endtask

  task automatic start(input logic v, input logic rw, input logic mw, input logic br,
                       input pc_src_t ps, input logic il);
    e = '0;
    c = '0;
    e.valid = v; e.reg_write = rw; e.mem_write = mw; e.branch = br; e.pc_src = ps; e.illegal = il;
    c[F_VALID] = 1'b1;
    c[F_CTRL]  = 1'b1;
  endtask

  task automatic set_rd(input logic [4:0] v);   e.rd = v;      c[F_RD] = 1'b1;  endtask
  task automatic set_rd1(input logic [31:0] v); e.rd1 = v;     c[F_RD1] = 1'b1; endtask
  task automatic set_rd2(input logic [31:0] v); e.rd2 = v;     c[F_RD2] = 1'b1; endtask
  task automatic set_imm(input logic [31:0] v); e.imm_ext = v; c[F_IMM] = 1'b1; endtask
  task automatic set_res(input result_src_t v); e.result_src = v; c[F_RES] = 1'b1; endtask
  task automatic set_pc(input logic [31:0] p);
    e.pc_cur = p; e.pc_plus_4 = p + 32'd4; c[F_PC] = 1'b1;
  endtask
  task automatic push(input string name);
    sb.push_back('{name: name, cyc: cyc + 1, exp: e, chk: c});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries never sampled, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    if_to_id = '0;

    // Held in reset with random stimulus: record must stay all zero.
    for (int i = 0; i < 3; i++) begin
      step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 5'($urandom), $urandom);
      start(1'b0, 1'b0, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
      c = '1;
      push("reset_hold");
    end

    step(32'h00528433); // ADD x8,x5,x5
    reset = 1'b1;
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_rd(5'd8); set_rd1(32'd0); set_rd2(32'd0); set_pc(last_pc);
    push("x5_zero_after_reset");

    step(32'h000283B3, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF); // ADD x7,x5,x0 with WB x5
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_rd(5'd7); set_rd1(32'hDEADBEEF); set_rd2(32'd0); set_pc(last_pc);
    push("wb_bypass");

    step(32'h000283B3);
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_rd(5'd7); set_rd1(32'hDEADBEEF);
    push("wb_stored");

    step(32'hFFF00093); // ADDI x1,x0,-1
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_rd(5'd1); set_imm(32'hFFFFFFFF); e.alu_src = 1'b1; c[F_ALU] = 1'b1;
    push("addi_imm_i");

    step(32'h80000063); // BEQ x0,x0,-4096
    start(1'b1, 1'b0, 1'b0, 1'b1, PC_SRC__INCREMENT, 1'b0);
    set_imm(32'hFFFFF000); set_rd(5'd0);
    push("beq_imm_b");

    step(32'h00209463); // BNE x1,x2,+8 (raw rd field is 8)
    start(1'b1, 1'b0, 1'b0, 1'b1, PC_SRC__INCREMENT, 1'b0);
    set_imm(32'd8); set_rd(5'd0);
    e.rs1 = 5'd1; e.rs2 = 5'd2; c[F_RS] = 1'b1; e.funct3 = 3'd1; c[F_F3] = 1'b1;
    push("bne_rd_forced_zero");

    step(32'h002000EF); // JAL x1,+2
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__JUMP, 1'b0);
    set_imm(32'd2); set_rd(5'd1); set_res(RESULT_SRC__PC_PLUS_4);
    push("jal_imm_j");

    step(32'h008100E7); // JALR x1,8(x2)
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__ALU_RESULT, 1'b0);
    set_imm(32'd8); set_rd(5'd1); set_res(RESULT_SRC__PC_PLUS_4);
    push("jalr_alu_result");

    step(32'hFE532E23); // SW x5,-4(x6)
    start(1'b1, 1'b0, 1'b1, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_imm(32'hFFFFFFFC); set_rd(5'd0); set_rd2(32'hDEADBEEF); e.alu_src = 1'b1; c[F_ALU] = 1'b1;
    push("sw_imm_s");

    step(32'h123451B7); // LUI x3,0x12345
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_imm(32'h12345000); set_rd(5'd3);
    push("lui_imm_u");

    step(32'h0102A203); // LW x4,16(x5)
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_imm(32'h00000010); set_rd(5'd4); set_rd1(32'hDEADBEEF); set_res(RESULT_SRC__MEM);
    push("lw_result_mem");

    step(32'h000004B3, 1'b0, 1'b0, 1'b1, 5'd0, 32'h00001234); // ADD x9,x0,x0 with WB x0
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_rd(5'd9); set_rd1(32'd0); set_rd2(32'd0);
    push("x0_write_bypass");
    step(32'h000004B3);
    push("x0_write_stored");

    step(32'h00028533); // ADD x10,x5,x0 then hold it
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_rd(5'd10); set_rd1(32'hDEADBEEF); set_pc(last_pc);
    push("stall_load");
    for (int k = 0; k < 3; k++) begin
      step((k == 0) ? 32'hFFF00093 : (k == 1) ? 32'h123451B7 : 32'h002000EF, 1'b1);
      push("stall_hold");
    end

    step(32'h00528433, 1'b1, 1'b1);
    start(1'b0, 1'b0, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_rd(5'd0);
    push("stall_flush_bubble");

    step(32'h0000007F);
    start(1'b1, 1'b0, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b1);
    push("illegal_opcode");

    drain();

    // Asynchronous reset in the middle of a valid record.
    step(32'h000283B3);
    @(posedge clk);
    #1;
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_rd(5'd7); set_rd1(32'hDEADBEEF);
    check("pre_reset_valid", id_to_ex, e, c);
    reset = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h00000001;
    #1;
    start(1'b0, 1'b0, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    c = '1;
    check("async_reset_clear", id_to_ex, e, c);

    step(32'h000283B3);
    reset = 1'b1;
    start(1'b1, 1'b1, 1'b0, 1'b0, PC_SRC__INCREMENT, 1'b0);
    set_rd(5'd7); set_rd1(32'd0);
    push("regs_cleared_by_reset");

    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
